// File: rtl/vec_match_engine_if.sv
// ROM read bus and result handshake of vec_match_engine.
// master is the engine side; slave is the ROM / downstream side.
interface vec_match_engine_if #(
   parameter int VEC_WIDTH = 1100,
   parameter int OBS_NUM   = 49,
   parameter int NAV_NUM   = 539,
   parameter int LANES     = 4
);
   localparam int NGRP = (NAV_NUM + LANES - 1) / LANES;
   localparam int SW   = $clog2(VEC_WIDTH + 1);
   localparam int OW   = (OBS_NUM > 1) ? $clog2(OBS_NUM) : 1;
   localparam int LW   = (NAV_NUM > 1) ? $clog2(NAV_NUM) : 1;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

   logic                       rd_en;
   logic [OW-1:0]              obs_addr;
   logic [GW-1:0]              nav_addr;
   logic [VEC_WIDTH-1:0]       obs_rdata;
   logic [LANES*VEC_WIDTH-1:0] nav_rdata;

   logic                       res_valid;
   logic                       res_ready;
   logic [OW-1:0]              res_obs_idx;
   logic [LW-1:0]              res_lib_idx;
   logic [SW-1:0]              res_score;
   logic                       res_hit;

   modport master (
      output rd_en, obs_addr, nav_addr,
      input  obs_rdata, nav_rdata,
      output res_valid, res_obs_idx, res_lib_idx, res_score, res_hit,
      input  res_ready
   );

   modport slave (
      input  rd_en, obs_addr, nav_addr,
      output obs_rdata, nav_rdata,
      input  res_valid, res_obs_idx, res_lib_idx, res_score, res_hit,
      output res_ready
   );
endinterface

// File: rtl/vec_match_engine.sv
// Observation-vs-library matcher: sweeps the library LANES vectors per cycle,
// scores popcount(obs & lib) and reports the best library index per observation.
module vec_match_engine #(
   parameter int  VEC_WIDTH = 1100,
   parameter int  OBS_NUM   = 49,
   parameter int  NAV_NUM   = 539,
   parameter int  LANES     = 4,
   parameter int  RD_LAT    = 1,
   localparam int NGRP      = (NAV_NUM + LANES - 1) / LANES,
   localparam int SW        = $clog2(VEC_WIDTH + 1),
   localparam int OW        = (OBS_NUM > 1) ? $clog2(OBS_NUM) : 1,
   localparam int LW        = (NAV_NUM > 1) ? $clog2(NAV_NUM) : 1,
   localparam int GW        = (NGRP > 1) ? $clog2(NGRP) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [SW-1:0] min_score,
   output logic          busy,
   output logic          done,
   vec_match_engine_if.master bus
);
   localparam int DW = $clog2(RD_LAT + 1);
   localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);
   localparam logic [OW-1:0] LAST_OBS = OW'(OBS_NUM - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

   state_t        state;
   logic          rd_en_q;
   logic [OW-1:0] obs_q;
   logic [GW-1:0] nav_q;
   logic [DW-1:0] drain_q;
   logic [SW-1:0] min_lat;
   logic [SW-1:0] best_score;
   logic [LW-1:0] best_idx;
   logic          busy_q;
   logic          done_q;
   logic          res_valid_q;
   logic [OW-1:0] res_obs_q;
   logic [LW-1:0] res_lib_q;
   logic [SW-1:0] res_score_q;
   logic          res_hit_q;

   logic [RD_LAT-1:0] vld_sr;
   logic [GW-1:0]     grp_sr [RD_LAT];
   logic [LANES-1:0]  lane_ok;
   logic              sc_valid;
   logic [GW-1:0]     sc_grp;
   logic [LANES-1:0]  sc_ok;
   logic [SW-1:0]     sc_score [LANES];

   logic          red_found;
   logic [SW-1:0] red_score;
   int            red_lane;
   logic [LW-1:0] red_idx;
   logic          best_upd;
   logic [SW-1:0] best_score_nxt;
   logic [LW-1:0] best_idx_nxt;

   function automatic logic [SW-1:0] popcount(input logic [VEC_WIDTH-1:0] v);
      logic [SW-1:0] c;
      c = '0;
      for (int i = 0; i < VEC_WIDTH; i++) begin
         c = c + SW'(v[i]);
      end
      return c;
   endfunction

   // Lanes past the end of the library exist only as ROM padding.
   always_comb begin
      lane_ok = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_ok[k] = (int'(grp_sr[RD_LAT-1]) * LANES + k) < NAV_NUM;
      end
   end

   // Read tracking shift register followed by the registered score stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr   <= '0;
         sc_valid <= 1'b0;
         sc_grp   <= '0;
         sc_ok    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            grp_sr[i] <= '0;
         end
         for (int k = 0; k < LANES; k++) begin
            sc_score[k] <= '0;
         end
      end else begin
         vld_sr[0] <= rd_en_q;
         grp_sr[0] <= nav_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            grp_sr[i] <= grp_sr[i-1];
         end
         sc_valid <= vld_sr[RD_LAT-1];
         sc_grp   <= grp_sr[RD_LAT-1];
         sc_ok    <= lane_ok;
         for (int k = 0; k < LANES; k++) begin
            sc_score[k] <= lane_ok[k]
               ? popcount(bus.obs_rdata & bus.nav_rdata[k*VEC_WIDTH +: VEC_WIDTH])
               : '0;
         end
      end
   end

   // Scanning upward with a strict compare keeps the lowest lane on ties.
   always_comb begin
      red_found = 1'b0;
      red_score = '0;
      red_lane  = 0;
      for (int k = 0; k < LANES; k++) begin
         if (sc_ok[k] && (!red_found || sc_score[k] > red_score)) begin
            red_found = 1'b1;
            red_score = sc_score[k];
            red_lane  = k;
         end
      end
      red_idx        = LW'(int'(sc_grp) * LANES + red_lane);
      best_upd       = sc_valid && red_found && (red_score > best_score);
      best_score_nxt = best_upd ? red_score : best_score;
      best_idx_nxt   = best_upd ? red_idx : best_idx;
   end

   // The last group reaches the running best exactly as DRAIN expires,
   // so the result record is loaded from the next-state best values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_en_q     <= 1'b0;
         obs_q       <= '0;
         nav_q       <= '0;
         drain_q     <= '0;
         min_lat     <= '0;
         best_score  <= '0;
         best_idx    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_obs_q   <= '0;
         res_lib_q   <= '0;
         res_score_q <= '0;
         res_hit_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (best_upd) begin
            best_score <= red_score;
            best_idx   <= red_idx;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  min_lat    <= min_score;
                  obs_q      <= '0;
                  nav_q      <= '0;
                  best_score <= '0;
                  best_idx   <= '0;
                  rd_en_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (nav_q == LAST_GRP) begin
                  rd_en_q <= 1'b0;
                  drain_q <= '0;
                  state   <= DRAIN;
               end else begin
                  nav_q <= nav_q + GW'(1);
               end
            end
            DRAIN: begin
               if (drain_q == DW'(RD_LAT)) begin
                  res_valid_q <= 1'b1;
                  res_obs_q   <= obs_q;
                  res_lib_q   <= best_idx_nxt;
                  res_score_q <= best_score_nxt;
                  res_hit_q   <= best_score_nxt >= min_lat;
                  state       <= RESULT;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  if (obs_q == LAST_OBS) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     obs_q      <= obs_q + OW'(1);
                     nav_q      <= '0;
                     best_score <= '0;
                     best_idx   <= '0;
                     rd_en_q    <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign bus.rd_en       = rd_en_q;
   assign bus.obs_addr    = obs_q;
   assign bus.nav_addr    = nav_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_obs_idx = res_obs_q;
   assign bus.res_lib_idx = res_lib_q;
   assign bus.res_score   = res_score_q;
   assign bus.res_hit     = res_hit_q;
endmodule
